axis_pingpong_scheduler: RTL and testbench
==========================================

# axis_pingpong_scheduler

Ping-pong bank scheduler between the tile producer and the BRAM-to-AXI-Stream serializer. Owns two frame-sized BRAM banks, grants an empty bank to the producer for filling, and hands full banks to the serializer in strict fill order. Drives the serializer's start/ready input, the bank-select muxes on both BRAM ports, and tracks per-bank occupancy so the producer never overwrites a bank that is still draining.

## Interface
- ADDR_WIDTH, 12, bank address width; passed through to the muxes, no internal use.
- FRAME_LEN, 1024, words per frame; documentation only, the serializer counts words.
- aclk  in  1  clock.
- aresetn  in  1  synchronous, active-low reset.
- prod_req  in  1  producer requests a bank to fill (level).
- prod_grant  out  1  producer owns `prod_bank`; held high from grant until commit.
- prod_bank  out  1  bank index the producer writes.
- prod_commit  in  1  single-cycle pulse: granted bank is completely written.
- ser_start  out  1  drives serializer `src_ready`; high for the whole drain.
- ser_bank  out  1  bank index the serializer reads.
- ser_done  in  1  single-cycle pulse from the serializer at end of frame.
- bank_full  out  2  bit i set while bank i is FULL or DRAINING.
- busy  out  1  any bank not EMPTY, or producer FSM in P_FILL.

## Operation
- Per-bank state: EMPTY, FILLING, FULL, DRAINING.
- Pointers: `wr_ptr` and `rd_ptr` are 1-bit and toggle on commit and on done respectively. This guarantees FIFO frame order.
- Producer FSM:
  - P_IDLE → P_FILL when `prod_req` is high and bank[`wr_ptr`] is EMPTY. That bank becomes FILLING, `prod_grant` goes to 1, and `prod_bank` is set to `wr_ptr`.
  - P_FILL → P_IDLE on `prod_commit`. The bank becomes FULL, `wr_ptr` toggles, and `prod_grant` goes to 0.
- Consumer FSM:
  - C_IDLE → C_DRAIN when bank[`rd_ptr`] is FULL. That bank becomes DRAINING, `ser_start` goes to 1, and `ser_bank` is set to `rd_ptr`.
  - C_DRAIN → C_IDLE on `ser_done`. The bank becomes EMPTY, `rd_ptr` toggles, and `ser_start` goes to 0.
- Ignored inputs:
  - `prod_commit` outside P_FILL is ignored.
  - `ser_done` outside C_DRAIN is ignored.
  - `prod_req` while in P_FILL has no effect.
- Simultaneous events:
  - Commit and done in the same cycle necessarily target different banks; both updates apply.
  - A done that empties bank[`wr_ptr`] in the same cycle as a pending `prod_req` does not grant that cycle. The grant follows one cycle later.
- Both banks FULL/DRAINING with `prod_req` high: producer waits in P_IDLE, `prod_grant` stays 0.
- Reset mid-operation: both FSMs go to idle, all banks EMPTY, pointers 0, all outputs 0. An in-flight serializer frame is abandoned; the serializer is reset by the same `aresetn`.

## Timing
- Reset values: `prod_grant`=0, `prod_bank`=0, `ser_start`=0, `ser_bank`=0, `bank_full`=2'b00, `busy`=0.
- All outputs are registered.
- Grant latency: `prod_req` sampled at edge N → `prod_grant`=1 after edge N.
- Commit-to-start: `prod_commit` sampled at edge N → bank FULL after N. With the consumer idle and `rd_ptr` pointing at that bank, `ser_start`=1 after edge N+1.
- Done-to-restart:
  - `ser_done` sampled at edge N → `ser_start`=0 after N.
  - If the other bank is FULL, `ser_start`=1 again after N+1.
  - `ser_start` is therefore low for at least one full cycle, while the serializer sits in its WAIT state.
- `ser_bank` is stable for the whole period `ser_start` is high. `prod_bank` is stable while `prod_grant` is high.

## Configuration
- `PP_STATS_EN` defined: adds two output ports.
  - `frames_sent[15:0]`: increments on each accepted `ser_done`, wraps at 16 bits.
  - `stall_cycles[15:0]`: increments each cycle `prod_req` is high while in P_IDLE with bank[`wr_ptr`] not EMPTY; saturates at 16'hFFFF.
  - Both reset to 0.
- `PP_STATS_EN` not defined: the ports and counters are absent; all other behaviour is identical.

## Test plan
- Reset, then `prod_req`=1 → `prod_grant`=1 and `prod_bank`=0 one cycle later; `ser_start`=0 and `bank_full`=00 throughout.
- Commit bank 0 at edge N → `bank_full`=01 after N; `ser_start`=1 and `ser_bank`=0 after N+1. `ser_done` 1030 cycles later → `bank_full`=00 and `ser_start`=0.
- Fill bank 0, then bank 1, before any `ser_done` → third `prod_req` is held, `prod_grant`=0. After the first `ser_done`, the grant reissues with `prod_bank`=0 two cycles later; serializer order is 0,1,0.
- `prod_commit` (bank 1) and `ser_done` (bank 0) in the same cycle → `bank_full`=10 next cycle, `ser_start`=0 for one cycle, then `ser_start`=1 with `ser_bank`=1.
- Spurious `prod_commit` in P_IDLE and spurious `ser_done` in C_IDLE → no state change. `aresetn`=0 during C_DRAIN → all outputs 0 next cycle.
- With `PP_STATS_EN`: 3 frames drained → `frames_sent`=3. Producer blocked 40 cycles with both banks full → `stall_cycles`=40.

Source files
------------

// File: rtl/axis_pingpong_scheduler.sv
// Ping-pong bank scheduler: grants empty BRAM banks to the tile producer and
// hands full banks to the AXI-Stream serializer in fill order. Optional
// statistics counters are compiled in when PP_STATS_EN is defined.
module axis_pingpong_scheduler #(
   parameter int ADDR_WIDTH = 12,
   parameter int FRAME_LEN  = 1024
) (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic        prod_req,
   output logic        prod_grant,
   output logic        prod_bank,
   input  logic        prod_commit,
   output logic        ser_start,
   output logic        ser_bank,
   input  logic        ser_done,
   output logic [1:0]  bank_full,
   output logic        busy
`ifdef PP_STATS_EN
   ,
   output logic [15:0] frames_sent,
   output logic [15:0] stall_cycles
`endif
);

   // Handshake contract: prod_req is a level held until prod_grant; prod_commit
   // and ser_done are single-cycle pulses honoured only while the matching FSM
   // owns a bank (P_FILL / C_DRAIN); ser_start stays high for the whole drain.

   localparam logic [0:0] P_IDLE    = 1'b0;
   localparam logic [0:0] P_FILL    = 1'b1;
   localparam logic [0:0] C_IDLE    = 1'b0;
   localparam logic [0:0] C_DRAIN   = 1'b1;

   localparam logic [1:0] B_EMPTY    = 2'd0;
   localparam logic [1:0] B_FILLING  = 2'd1;
   localparam logic [1:0] B_FULL     = 2'd2;
   localparam logic [1:0] B_DRAINING = 2'd3;

   // The address width and frame length only matter to the muxes and the
   // serializer; reject nonsensical values at elaboration.
   if (ADDR_WIDTH < 1 || FRAME_LEN < 1) begin : g_cfg_check
      $error("axis_pingpong_scheduler: ADDR_WIDTH and FRAME_LEN must be >= 1");
   end

   logic [0:0] p_state_q, p_state_d;
   logic [0:0] c_state_q, c_state_d;
   logic [1:0] bank_q [2];
   logic [1:0] bank_d [2];
   logic       wr_ptr_q, wr_ptr_d;
   logic       rd_ptr_q, rd_ptr_d;
   logic       prod_bank_q, prod_bank_d;
   logic       ser_bank_q, ser_bank_d;
   logic       prod_grant_q, ser_start_q, busy_q;
   logic [1:0] bank_full_q;
   logic       done_acc;
   logic       stall_evt;

   always_comb begin
      p_state_d   = p_state_q;
      c_state_d   = c_state_q;
      bank_d      = bank_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      prod_bank_d = prod_bank_q;
      ser_bank_d  = ser_bank_q;
      done_acc    = 1'b0;
      stall_evt   = 1'b0;

      // Decisions read only registered bank state, so a bank freed by ser_done
      // this cycle is granted on the following cycle.
      case (p_state_q)
         P_IDLE: begin
            if (prod_req) begin
               if (bank_q[wr_ptr_q] == B_EMPTY) begin
                  p_state_d         = P_FILL;
                  bank_d[wr_ptr_q]  = B_FILLING;
                  prod_bank_d       = wr_ptr_q;
               end else begin
                  stall_evt = 1'b1;
               end
            end
         end
         P_FILL: begin
            if (prod_commit) begin
               p_state_d            = P_IDLE;
               bank_d[prod_bank_q]  = B_FULL;
               wr_ptr_d             = ~wr_ptr_q;
            end
         end
         default: p_state_d = P_IDLE;
      endcase

      // Commit and done always address different banks, so both writes stand.
      case (c_state_q)
         C_IDLE: begin
            if (bank_q[rd_ptr_q] == B_FULL) begin
               c_state_d        = C_DRAIN;
               bank_d[rd_ptr_q] = B_DRAINING;
               ser_bank_d       = rd_ptr_q;
            end
         end
         C_DRAIN: begin
            if (ser_done) begin
               c_state_d          = C_IDLE;
               bank_d[ser_bank_q] = B_EMPTY;
               rd_ptr_d           = ~rd_ptr_q;
               done_acc           = 1'b1;
            end
         end
         default: c_state_d = C_IDLE;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         p_state_q    <= P_IDLE;
         c_state_q    <= C_IDLE;
         bank_q[0]    <= B_EMPTY;
         bank_q[1]    <= B_EMPTY;
         wr_ptr_q     <= 1'b0;
         rd_ptr_q     <= 1'b0;
         prod_bank_q  <= 1'b0;
         ser_bank_q   <= 1'b0;
         prod_grant_q <= 1'b0;
         ser_start_q  <= 1'b0;
         bank_full_q  <= 2'b00;
         busy_q       <= 1'b0;
      end else begin
         p_state_q    <= p_state_d;
         c_state_q    <= c_state_d;
         bank_q[0]    <= bank_d[0];
         bank_q[1]    <= bank_d[1];
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         prod_bank_q  <= prod_bank_d;
         ser_bank_q   <= ser_bank_d;
         prod_grant_q <= (p_state_d == P_FILL);
         ser_start_q  <= (c_state_d == C_DRAIN);
         bank_full_q  <= {(bank_d[1] == B_FULL) || (bank_d[1] == B_DRAINING),
                          (bank_d[0] == B_FULL) || (bank_d[0] == B_DRAINING)};
         busy_q       <= (bank_d[0] != B_EMPTY) || (bank_d[1] != B_EMPTY) ||
                         (p_state_d == P_FILL);
      end
   end

   assign prod_grant = prod_grant_q;
   assign prod_bank  = prod_bank_q;
   assign ser_start  = ser_start_q;
   assign ser_bank   = ser_bank_q;
   assign bank_full  = bank_full_q;
   assign busy       = busy_q;

`ifdef PP_STATS_EN
   logic [15:0] frames_q;
   logic [15:0] stall_q;

   // frames_sent wraps naturally; stall_cycles pins at all-ones.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         frames_q <= 16'd0;
         stall_q  <= 16'd0;
      end else begin
         if (done_acc) frames_q <= frames_q + 16'd1;
         if (stall_evt && (stall_q != 16'hFFFF)) stall_q <= stall_q + 16'd1;
      end
   end

   assign frames_sent  = frames_q;
   assign stall_cycles = stall_q;
`else
   logic unused_stats;
   assign unused_stats = done_acc ^ stall_evt;
`endif

endmodule

// File: tb/tb_axis_pingpong_scheduler.sv
// Bench for axis_pingpong_scheduler: directed walk through the frame hand-off
// scenarios followed by randomized traffic, all checked against a frame-level model.
module tb_axis_pingpong_scheduler;

   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic        prod_req = 1'b0;
   logic        prod_commit = 1'b0;
   logic        ser_done = 1'b0;
   logic        prod_grant, prod_bank, ser_start, ser_bank, busy;
   logic [1:0]  bank_full;
`ifdef PP_STATS_EN
   logic [15:0] frames_sent, stall_cycles;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   // Frame-level model: which bank the producer holds, which bank is being
   // drained, and the committed frames waiting for the serializer, oldest first.
   int          owned    = -1;
   int          draining = -1;
   int          wr_next  = 0;
   int          last_pb  = 0;
   int          last_sb  = 0;
   logic [0:0]  exp_q[$];
   logic [15:0] m_frames = 16'd0;
   logic [15:0] m_stall  = 16'd0;

   axis_pingpong_scheduler #(.ADDR_WIDTH(12), .FRAME_LEN(1024)) dut (
      .aclk        (aclk),
      .aresetn     (aresetn),
      .prod_req    (prod_req),
      .prod_grant  (prod_grant),
      .prod_bank   (prod_bank),
      .prod_commit (prod_commit),
      .ser_start   (ser_start),
      .ser_bank    (ser_bank),
      .ser_done    (ser_done),
      .bank_full   (bank_full),
      .busy        (busy)
`ifdef PP_STATS_EN
      ,
      .frames_sent (frames_sent),
      .stall_cycles(stall_cycles)
`endif
   );

   always #5 aclk = ~aclk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit occ(int b);
      bit o = (owned == b) || (draining == b);
      foreach (exp_q[i]) if (int'(exp_q[i]) == b) o = 1'b1;
      return o;
   endfunction

   function automatic logic [1:0] exp_full();
      logic [1:0] f = 2'b00;
      foreach (exp_q[i]) f[exp_q[i]] = 1'b1;
      if (draining >= 0) f[draining] = 1'b1;
      return f;
   endfunction

   task automatic model_edge();
      bit g, c, s, d, st;
      if (!aresetn) begin
         owned = -1; draining = -1; wr_next = 0; last_pb = 0; last_sb = 0;
         exp_q.delete();
         m_frames = 16'd0; m_stall = 16'd0;
         return;
      end
      g  = (owned < 0) && prod_req && !occ(wr_next);
      st = (owned < 0) && prod_req && occ(wr_next);
      c  = (owned >= 0) && prod_commit;
      s  = (draining < 0) && (exp_q.size() > 0);
      d  = (draining >= 0) && ser_done;
      if (s) begin
         draining = int'(exp_q.pop_front());
         last_sb  = draining;
      end
      if (d) begin
         draining = -1;
         m_frames = m_frames + 16'd1;
      end
      if (c) begin
         exp_q.push_back(owned[0:0]);
         owned   = -1;
         wr_next = 1 - wr_next;
      end
      if (g) begin
         owned   = wr_next;
         last_pb = wr_next;
      end
      if (st && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
   endtask

   task automatic step();
      @(posedge aclk);
      model_edge();
      #1;
      chk("prod_grant", prod_grant, (owned >= 0));
      chk("prod_bank", prod_bank, last_pb);
      chk("ser_start", ser_start, (draining >= 0));
      chk("ser_bank", ser_bank, last_sb);
      chk("bank_full", bank_full, exp_full());
      chk("busy", busy, (owned >= 0) || (draining >= 0) || (exp_q.size() > 0));
`ifdef PP_STATS_EN
      chk("frames_sent", frames_sent, m_frames);
      chk("stall_cycles", stall_cycles, m_stall);
`endif
   endtask

   task automatic cyc(input bit r, input bit c, input bit d);
      prod_req = r; prod_commit = c; ser_done = d;
      step();
      prod_commit = 1'b0; ser_done = 1'b0;
   endtask

   initial begin
      // Reset
      aresetn = 1'b0;
      cyc(0, 0, 0);
      cyc(0, 0, 0);
      chk("rst_outs", {prod_grant, prod_bank, ser_start, ser_bank, bank_full, busy}, 32'd0);
      aresetn = 1'b1;

      // First grant and first frame hand-off
      cyc(1, 0, 0);
      chk("grant_lat", prod_grant, 1);
      chk("grant_bank", prod_bank, 0);
      chk("no_start", ser_start, 0);
      chk("no_full", bank_full, 2'b00);
      cyc(0, 1, 0);
      chk("commit_full", bank_full, 2'b01);
      chk("start_not_yet", ser_start, 0);
      cyc(0, 0, 0);
      chk("start_n1", ser_start, 1);
      chk("ser_bank0", ser_bank, 0);
      repeat (1030) cyc(0, 0, 0);
      cyc(0, 0, 1);
      chk("done_empty", bank_full, 2'b00);
      chk("done_stop", ser_start, 0);

      // Two banks filled, third request held
      cyc(1, 0, 0);
      chk("grant_b1", prod_bank, 1);
      cyc(0, 1, 0);
      cyc(1, 0, 0);
      chk("grant_b0", prod_bank, 0);
      chk("drain_b1", ser_bank, 1);
      cyc(0, 1, 0);
      chk("both_full", bank_full, 2'b11);
      repeat (40) cyc(1, 0, 0);
      chk("held_grant", prod_grant, 0);
`ifdef PP_STATS_EN
      chk("stall40", stall_cycles, 40);
`endif
      cyc(1, 0, 1);
      chk("no_grant_same", prod_grant, 0);
      cyc(1, 0, 0);
      chk("regrant", prod_grant, 1);
      chk("regrant_bank", prod_bank, 1);
      chk("drain_b0_again", ser_bank, 0);
      chk("restart", ser_start, 1);

      // Commit and done in the same cycle
      cyc(0, 1, 1);
      chk("simul_full", bank_full, 2'b10);
      chk("simul_gap", ser_start, 0);
      cyc(0, 0, 0);
      chk("simul_start", ser_start, 1);
      chk("simul_bank", ser_bank, 1);
`ifdef PP_STATS_EN
      chk("frames3", frames_sent, 3);
`endif

      // Spurious pulses
      cyc(0, 1, 0);
      chk("spur_commit", bank_full, 2'b10);
      chk("spur_commit_g", prod_grant, 0);
      cyc(0, 0, 1);
      cyc(0, 0, 1);
      chk("spur_done", {ser_start, bank_full, busy}, 4'b0000);

      // Reset while draining
      cyc(1, 0, 0);
      cyc(0, 1, 0);
      cyc(0, 0, 0);
      chk("pre_rst_drain", ser_start, 1);
      aresetn = 1'b0;
      cyc(0, 0, 0);
      chk("rst_mid", {prod_grant, prod_bank, ser_start, ser_bank, bank_full, busy}, 32'd0);
      aresetn = 1'b1;

      // Randomized traffic
      for (int i = 0; i < 4000; i++) begin
         prod_req    = ($urandom_range(99) < 70);
         prod_commit = (owned >= 0) ? ($urandom_range(99) < 20) : ($urandom_range(99) < 5);
         ser_done    = (draining >= 0) ? ($urandom_range(99) < 15) : ($urandom_range(99) < 5);
         aresetn     = ($urandom_range(999) >= 8);
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
